// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard bundle: decoder-side operand/producer info in,
// stall / scoreboard status out.
interface hazard_scoreboard_if #(
  parameter int NREG = 32,
  parameter int REGW = 5,
  parameter int TW   = 3
);
  logic            d_valid;
  logic            flush;
  logic [REGW-1:0] d_rs;
  logic [REGW-1:0] d_rt;
  logic            d_rs_use;
  logic            d_rt_use;
  logic [TW-1:0]   d_rs_tuse;
  logic [TW-1:0]   d_rt_tuse;
  logic            d_wr;
  logic [REGW-1:0] d_wa;
  logic [TW-1:0]   d_tnew;
  logic            d_md_start;
  logic            d_md_div;
  logic            d_md_access;
  logic            stall;
  logic            stall_data;
  logic            stall_md;
  logic            md_busy;
  logic [NREG-1:0] pending;

  modport master (
    output d_valid, flush, d_rs, d_rt,
    output d_rs_use, d_rt_use,
    output d_rs_tuse, d_rt_tuse,
    output d_wr, d_wa, d_tnew,
    output d_md_start, d_md_div, d_md_access,
    input  stall, stall_data, stall_md,
    input  md_busy, pending
  );

  modport slave (
    input  d_valid, flush, d_rs, d_rt,
    input  d_rs_use, d_rt_use,
    input  d_rs_tuse, d_rt_tuse,
    input  d_wr, d_wa, d_tnew,
    input  d_md_start, d_md_div, d_md_access,
    output stall, stall_data, stall_md,
    output md_busy, pending
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register Tnew countdown scoreboard plus mult/div busy timer.
// Ports: clk, rst_n (async low), hz (slave: D inputs, stall/status out).
module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int REGW    = 5,
  parameter int TW      = 3,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic clk,
  input  logic rst_n,
  hazard_scoreboard_if.slave hz
);

  localparam logic [7:0] MUL_LD = 8'(MUL_CYC);
  localparam logic [7:0] DIV_LD = 8'(DIV_CYC);

  logic [TW-1:0] cnt_q [NREG];
  logic [TW-1:0] cnt_d [NREG];
  logic [7:0]    md_cnt_q;
  logic [7:0]    md_cnt_d;

  logic [TW-1:0] rs_cnt;
  logic [TW-1:0] rt_cnt;
  logic          rs_haz;
  logic          rt_haz;
  logic          md_busy;
  logic          stall_data;
  logic          stall_md;
  logic          stall;
  logic          issue;

  // Index by compare so register numbers >= NREG read as 0.
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (hz.d_rs == REGW'(r)) rs_cnt = cnt_q[r];
      if (hz.d_rt == REGW'(r)) rt_cnt = cnt_q[r];
    end
  end

  assign rs_haz = hz.d_rs_use && (hz.d_rs != '0)
               && (rs_cnt > hz.d_rs_tuse);
  assign rt_haz = hz.d_rt_use && (hz.d_rt != '0)
               && (rt_cnt > hz.d_rt_tuse);

  assign md_busy    = (md_cnt_q != 8'd0);
  assign stall_data = hz.d_valid && (rs_haz || rt_haz);
  assign stall_md   = hz.d_valid && hz.d_md_access && md_busy;
  assign stall      = stall_data || stall_md;
  assign issue      = hz.d_valid && !hz.flush && !stall;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - TW'(1) : '0;
      if (r != 0 && issue && hz.d_wr && hz.d_wa == REGW'(r))
        cnt_d[r] = hz.d_tnew;
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    md_cnt_d = md_busy ? md_cnt_q - 8'd1 : 8'd0;
    if (issue && hz.d_md_start)
      md_cnt_d = hz.d_md_div ? DIV_LD : MUL_LD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      md_cnt_q <= 8'd0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    hz.pending = '0;
    for (int r = 1; r < NREG; r++)
      hz.pending[r] = (cnt_q[r] != '0);
  end

  assign hz.stall      = stall;
  assign hz.stall_data = stall_data;
  assign hz.stall_md   = stall_md;
  assign hz.md_busy    = md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, branch, r0,
// mult/div timer, flush, last-writer and async reset.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(32), .REGW(5), .TW(3)) hz ();

  hazard_scoreboard #(
    .NREG(32), .REGW(5), .TW(3), .MUL_CYC(5), .DIV_CYC(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  task automatic idle();
    hz.d_valid     = 1'b0;
    hz.flush       = 1'b0;
    hz.d_rs        = '0;
    hz.d_rt        = '0;
    hz.d_rs_use    = 1'b0;
    hz.d_rt_use    = 1'b0;
    hz.d_rs_tuse   = '0;
    hz.d_rt_tuse   = '0;
    hz.d_wr        = 1'b0;
    hz.d_wa        = '0;
    hz.d_tnew      = '0;
    hz.d_md_start  = 1'b0;
    hz.d_md_div    = 1'b0;
    hz.d_md_access = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic producer(input logic [4:0] wa, input logic [2:0] tn);
    idle();
    hz.d_valid = 1'b1;
    hz.d_wr    = 1'b1;
    hz.d_wa    = wa;
    hz.d_tnew  = tn;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    hz.d_valid     = 1'b1;
    hz.d_rs        = 5'd5;
    hz.d_rs_use    = 1'b1;
    hz.d_md_access = 1'b1;
    hz.d_wr        = 1'b1;
    hz.d_wa        = 5'd5;
    hz.d_tnew      = 3'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (hz.stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_stall: got %b want 0", hz.stall);
    end
    n_cmp++;
    if (hz.pending !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_pending: got %h want 0", hz.pending);
    end
    n_cmp++;
    if (hz.md_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_md_busy: got %b want 0", hz.md_busy);
    end
    idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    producer(5'd8, 3'd2);
    @(negedge clk);
    n_cmp++;
    if (hz.stall !== 1'b0) begin
      n_bad++;
      $display("FAIL lu_prod_stall: got %b want 0", hz.stall);
    end
    step();
    // addu reads r8 (tuse 1) and itself writes r10
    idle();
    hz.d_valid   = 1'b1;
    hz.d_rs      = 5'd8;
    hz.d_rs_use  = 1'b1;
    hz.d_rs_tuse = 3'd1;
    hz.d_wr      = 1'b1;
    hz.d_wa      = 5'd10;
    hz.d_tnew    = 3'd1;
    @(negedge clk);
    n_cmp++;
    if (hz.pending[8] !== 1'b1) begin
      n_bad++;
      $display("FAIL lu_pend8: got %b want 1", hz.pending[8]);
    end
    n_cmp++;
    if ({hz.stall, hz.stall_data, hz.stall_md} !== 3'b110) begin
      n_bad++;
      $display("FAIL lu_stall1: got %b want 110",
               {hz.stall, hz.stall_data, hz.stall_md});
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (hz.stall !== 1'b0) begin
      n_bad++;
      $display("FAIL lu_stall2: got %b want 0", hz.stall);
    end
    n_cmp++;
    if (hz.pending[10] !== 1'b0) begin
      n_bad++;
      $display("FAIL lu_no_issue: pend10 got %b want 0", hz.pending[10]);
    end
    step();
    idle();
    @(negedge clk);
    n_cmp++;
    if (hz.pending !== 32'h0000_0400) begin
      n_bad++;
      $display("FAIL lu_after: pending got %h want 00000400", hz.pending);
    end
    step();
  endtask

  task automatic test_branch();
    producer(5'd3, 3'd1);
    step();
    idle();
    hz.d_valid  = 1'b1;
    hz.d_rt     = 5'd3;
    hz.d_rt_use = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (hz.stall_data !== 1'b1) begin
      n_bad++;
      $display("FAIL br_stall: got %b want 1", hz.stall_data);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (hz.stall_data !== 1'b0) begin
      n_bad++;
      $display("FAIL br_clear: got %b want 0", hz.stall_data);
    end
    step();
    producer(5'd3, 3'd1);
    step();
    idle();
    hz.d_valid  = 1'b1;
    hz.d_rt     = 5'd3;
    hz.d_rt_use = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (hz.stall !== 1'b0) begin
      n_bad++;
      $display("FAIL br_nouse: got %b want 0", hz.stall);
    end
    step();
    idle();
  endtask

  task automatic test_reg0();
    producer(5'd0, 3'd2);
    step();
    idle();
    hz.d_valid  = 1'b1;
    hz.d_rs     = 5'd0;
    hz.d_rs_use = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (hz.stall !== 1'b0) begin
      n_bad++;
      $display("FAIL r0_stall: got %b want 0", hz.stall);
    end
    n_cmp++;
    if (hz.pending !== 32'h0) begin
      n_bad++;
      $display("FAIL r0_pending: got %h want 0", hz.pending);
    end
    step();
    idle();
  endtask

  task automatic md_run(input logic div, input int want, input string nm);
    int n;
    idle();
    hz.d_valid     = 1'b1;
    hz.d_md_start  = 1'b1;
    hz.d_md_div    = div;
    hz.d_md_access = 1'b1;
    step();
    idle();
    hz.d_valid     = 1'b1;
    hz.d_md_access = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!hz.stall_md) break;
      if (!hz.md_busy) break;
      n++;
      step();
    end
    n_cmp++;
    if (n !== want) begin
      n_bad++;
      $display("FAIL %s_cycles: got %0d want %0d", nm, n, want);
    end
    n_cmp++;
    if (hz.md_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_busy_end: got %b want 0", nm, hz.md_busy);
    end
    step();
    idle();
  endtask

  task automatic test_md();
    md_run(1'b1, 10, "div");
    md_run(1'b0, 5, "mult");
  endtask

  task automatic test_flush();
    producer(5'd9, 3'd3);
    hz.flush      = 1'b1;
    hz.d_md_start = 1'b1;
    step();
    idle();
    @(negedge clk);
    n_cmp++;
    if (hz.pending[9] !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_pend9: got %b want 0", hz.pending[9]);
    end
    n_cmp++;
    if (hz.md_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL fl_md_busy: got %b want 0", hz.md_busy);
    end
    step();
  endtask

  task automatic test_last_writer();
    int n;
    producer(5'd4, 3'd7);
    step();
    producer(5'd4, 3'd2);
    step();
    idle();
    hz.d_valid  = 1'b1;
    hz.d_rs     = 5'd4;
    hz.d_rs_use = 1'b1;
    n = 0;
    while (n < 12) begin
      @(negedge clk);
      if (!hz.stall) break;
      n++;
      step();
    end
    n_cmp++;
    if (n !== 2) begin
      n_bad++;
      $display("FAIL lw_stall_cycles: got %0d want 2", n);
    end
    step();
    idle();
  endtask

  task automatic test_reset_mid_stall();
    producer(5'd8, 3'd3);
    step();
    idle();
    hz.d_valid  = 1'b1;
    hz.d_rs     = 5'd8;
    hz.d_rs_use = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (hz.stall !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_pre: got %b want 1", hz.stall);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hz.stall, hz.pending[8]} !== 2'b00) begin
      n_bad++;
      $display("FAIL rm_async: got %b want 00",
               {hz.stall, hz.pending[8]});
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (hz.stall !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_post: got %b want 0", hz.stall);
    end
    step();
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_reg0();
    test_md();
    test_flush();
    test_last_writer();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
